// File: rtl/trng_ctrl_pkg.sv
// Shared defaults and helpers for the ring-oscillator TRNG sequencer.
// Imported by trng_ctrl and trng_rep_test.
package trng_ctrl_pkg;

  localparam int TRNG_WORD_W     = 32;
  localparam int TRNG_WARMUP     = 256;
  localparam int TRNG_SAMPLE_DIV = 4;
  localparam int TRNG_REP_LIMIT  = 32;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int trng_cw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/trng_rep_test.sv
// Repetition-count health test: tracks the last sampled bit and a saturating
// run length, and flags a trip on the sample that brings the run to REP_LIMIT.
module trng_rep_test
  import trng_ctrl_pkg::*;
#(
  parameter int REP_LIMIT = TRNG_REP_LIMIT
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_sample_en,
  input  logic i_bit,
  output logic o_trip
);

  logic       r_last;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_nxt;

  // A zero count means no sample seen yet since clear, so the run restarts at 1.
  always_comb begin
    w_cnt_nxt = 8'd1;
    if (r_cnt != 8'd0 && i_bit == r_last)
      w_cnt_nxt = (r_cnt == 8'hFF) ? 8'hFF : r_cnt + 8'd1;
  end

  // Combinational so the controller can act on the same edge that would
  // register the offending count.
  assign o_trip = i_sample_en && (w_cnt_nxt >= 8'(REP_LIMIT));

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_last <= 1'b0;
      r_cnt  <= 8'd0;
    end else if (i_clear) begin
      r_last <= 1'b0;
      r_cnt  <= 8'd0;
    end else if (i_sample_en) begin
      r_last <= i_bit;
      r_cnt  <= w_cnt_nxt;
    end
  end

endmodule

// File: rtl/trng_ctrl.sv
// TRNG sequencer: enables the RO bank, waits out settling, decimates raw bits,
// health-checks them and hands packed words downstream over valid/ready.
module trng_ctrl
  import trng_ctrl_pkg::*;
#(
  parameter int WORD_W        = TRNG_WORD_W,
  parameter int WARMUP_CYCLES = TRNG_WARMUP,
  parameter int SAMPLE_DIV    = TRNG_SAMPLE_DIV,
  parameter int REP_LIMIT     = TRNG_REP_LIMIT
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic              i_clear_fault,
  input  logic              i_raw_bit,
  output logic              o_ro_enable,
  output logic [WORD_W-1:0] o_word_out,
  output logic              o_word_valid,
  input  logic              i_word_ready,
  output logic              o_health_fail,
  output logic              o_busy
);

  localparam int WW = trng_cw(WARMUP_CYCLES);
  localparam int DW = trng_cw(SAMPLE_DIV);
  localparam int BW = trng_cw(WORD_W);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WARMUP  = 3'd1,
    S_COLLECT = 3'd2,
    S_HOLD    = 3'd3,
    S_FAULT   = 3'd4
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [WW-1:0]     r_warm_cnt;
  logic [DW-1:0]     r_div;
  logic [BW-1:0]     r_bit_cnt;
  logic [WORD_W-1:0] r_word;
  logic              r_ro_en, r_valid, r_fail, r_busy;

  logic w_sample, w_trip, w_hs, w_word_done, w_warm_done, w_enter_warm, w_active;

  assign w_sample     = (r_state == S_COLLECT) && (r_div == DW'(SAMPLE_DIV - 1));
  assign w_word_done  = w_sample && (r_bit_cnt == BW'(WORD_W - 1));
  assign w_warm_done  = (r_state == S_WARMUP) && (r_warm_cnt == WW'(WARMUP_CYCLES - 1));
  assign w_hs         = (r_state == S_HOLD) && r_valid && i_word_ready;
  assign w_enter_warm = (r_state == S_IDLE) && (w_state_nxt == S_WARMUP);

  trng_rep_test #(.REP_LIMIT(REP_LIMIT)) u_rep (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_clear     (w_enter_warm),
    .i_sample_en (w_sample),
    .i_bit       (i_raw_bit),
    .o_trip      (w_trip)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Priority inside COLLECT: health trip, then stop, then word completion.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:    if (i_start && !i_stop) w_state_nxt = S_WARMUP;
      S_WARMUP:  if (i_stop) w_state_nxt = S_IDLE;
                 else if (w_warm_done) w_state_nxt = S_COLLECT;
      S_COLLECT: if (w_trip) w_state_nxt = S_FAULT;
                 else if (i_stop) w_state_nxt = S_IDLE;
                 else if (w_word_done) w_state_nxt = S_HOLD;
      S_HOLD:    if (i_stop) w_state_nxt = S_IDLE;
                 else if (w_hs) w_state_nxt = S_COLLECT;
      S_FAULT:   if (i_clear_fault) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  assign w_active = (w_state_nxt == S_WARMUP) || (w_state_nxt == S_COLLECT) ||
                    (w_state_nxt == S_HOLD);

  // Status outputs are registered images of the next state.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_ro_en <= 1'b0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_fail  <= 1'b0;
    end else begin
      r_ro_en <= w_active;
      r_busy  <= w_active;
      r_valid <= (w_state_nxt == S_HOLD);
      r_fail  <= (w_state_nxt == S_FAULT);
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_warm_cnt <= '0;
      r_div      <= '0;
      r_bit_cnt  <= '0;
      r_word     <= '0;
    end else begin
      if (w_enter_warm)              r_warm_cnt <= '0;
      else if (r_state == S_WARMUP)  r_warm_cnt <= r_warm_cnt + WW'(1);

      // Divider only runs in COLLECT, so each new collect phase starts at 0.
      if (r_state != S_COLLECT) r_div <= '0;
      else if (w_sample)        r_div <= '0;
      else                      r_div <= r_div + DW'(1);

      if (w_enter_warm || w_hs) r_bit_cnt <= '0;
      else if (w_sample)        r_bit_cnt <= r_bit_cnt + BW'(1);

      if (w_enter_warm)  r_word <= '0;
      else if (w_sample) r_word <= {r_word[WORD_W-2:0], i_raw_bit};
    end
  end

  assign o_ro_enable   = r_ro_en;
  assign o_busy        = r_busy;
  assign o_word_valid  = r_valid;
  assign o_health_fail = r_fail;
  assign o_word_out    = r_word;

endmodule

// File: tb/tb_trng_ctrl.sv
// Directed bench for trng_ctrl with WORD_W=8, WARMUP=4, SAMPLE_DIV=2, REP_LIMIT=5.
module tb_trng_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, stop, clr, raw, ready;
  logic       ro_en, valid, fail, busy;
  logic [7:0] word;

  int n_checks = 0;
  int n_errors = 0;

  trng_ctrl #(.WORD_W(8), .WARMUP_CYCLES(4), .SAMPLE_DIV(2), .REP_LIMIT(5)) dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_start       (start),
    .i_stop        (stop),
    .i_clear_fault (clr),
    .i_raw_bit     (raw),
    .o_ro_enable   (ro_en),
    .o_word_out    (word),
    .o_word_valid  (valid),
    .i_word_ready  (ready),
    .o_health_fail (fail),
    .o_busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       st, sp, cl, rw, rdy;
    logic       ro, vl;
    logic [7:0] wd;
    logic       ckw, fl, bs;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic st, sp, cl, rw, rdy, ro, vl,
                     input logic [7:0] wd, input logic ckw, fl, bs);
    vec_t v;
    v.st = st; v.sp = sp; v.cl = cl; v.rw = rw; v.rdy = rdy;
    v.ro = ro; v.vl = vl; v.wd = wd; v.ckw = ckw; v.fl = fl; v.bs = bs;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raw bit is driven to the complement on the off-phase cycle so a sample
  // taken on the wrong edge corrupts the word.
  task automatic feed(input logic b);
    raw = ~b; tick();
    raw = b;  tick();
  endtask

  task automatic feed_word(input logic [7:0] w);
    for (int k = 7; k >= 0; k--) feed(w[k]);
  endtask

  task automatic start_run(input string tag);
    start = 1'b1; tick(); start = 1'b0;
    chk({tag, "_ro_rise"}, ro_en, 1);
    chk({tag, "_busy_rise"}, busy, 1);
    repeat (4) tick();
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_ro"}, ro_en, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_word"}, word, 0);
    chk({tag, "_fail"}, fail, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    logic [7:0] pat;
    logic       b;
    rst = 1'b1; start = 0; stop = 0; clr = 0; raw = 0; ready = 0;
    repeat (3) tick();
    all_zero("reset");
    rst = 1'b0;
    tick();
    all_zero("idle");

    // Alternating 1,0 stream, consumer always ready, then stop, then stop+start.
    pat = 8'hAA;
    add(1,0,0,0,1, 1,0,8'h00,0,0,1);
    for (int i = 0; i < 4; i++) add(0,0,0,0,1, 1,0,8'h00,0,0,1);
    for (int k = 0; k < 8; k++) begin
      b = pat[7-k];
      add(0,0,0,~b,1, 1,0,8'h00,0,0,1);
      add(0,0,0,b,1, 1,(k == 7),8'hAA,(k == 7),0,1);
    end
    add(0,0,0,0,1, 1,0,8'h00,0,0,1);
    add(0,1,0,0,1, 0,0,8'h00,0,0,0);
    add(1,1,0,0,1, 0,0,8'h00,0,0,0);

    foreach (vecs[i]) begin
      start = vecs[i].st; stop = vecs[i].sp; clr = vecs[i].cl;
      raw = vecs[i].rw; ready = vecs[i].rdy;
      tick();
      chk($sformatf("vec%0d_ro", i), ro_en, vecs[i].ro);
      chk($sformatf("vec%0d_valid", i), valid, vecs[i].vl);
      chk($sformatf("vec%0d_fail", i), fail, vecs[i].fl);
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].bs);
      if (vecs[i].ckw) chk($sformatf("vec%0d_word", i), word, vecs[i].wd);
    end
    start = 0; stop = 0; clr = 0; ready = 0;

    // Constant 1: trips on the fifth sample, start ignored in FAULT.
    start_run("const");
    repeat (4) feed(1'b1);
    chk("const_no_trip_at_4", fail, 0);
    chk("const_ro_at_4", ro_en, 1);
    feed(1'b1);
    chk("const_trip_fail", fail, 1);
    chk("const_trip_ro", ro_en, 0);
    chk("const_trip_valid", valid, 0);
    chk("const_trip_busy", busy, 0);
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    chk("fault_start_ignored_busy", busy, 0);
    chk("fault_sticky", fail, 1);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("clear_fail", fail, 0);
    chk("clear_busy", busy, 0);

    // Backpressure with the 1,1,1,1,0 pattern; count carries across HOLD.
    start_run("bp");
    feed_word(8'hF7);
    chk("bp_valid", valid, 1);
    chk("bp_word", word, 8'hF7);
    for (int i = 0; i < 10; i++) begin
      raw = ~raw; tick();
      chk($sformatf("bp_hold%0d_valid", i), valid, 1);
      chk($sformatf("bp_hold%0d_word", i), word, 8'hF7);
    end
    ready = 1'b1; tick(); ready = 1'b0;
    chk("bp_hs_valid", valid, 0);
    chk("bp_hs_busy", busy, 1);
    feed_word(8'hBD);
    chk("bp2_valid", valid, 1);
    chk("bp2_word", word, 8'hBD);
    chk("bp2_fail", fail, 0);
    ready = 1'b1; tick(); ready = 1'b0;
    repeat (3) feed(1'b1);
    chk("carry_no_trip", fail, 0);
    feed(1'b1);
    chk("carry_trip", fail, 1);
    clr = 1'b1; tick(); clr = 1'b0;

    // Stop mid-word, then a fresh 0xCC word with no leftover bits.
    start_run("stop");
    feed(1'b1); feed(1'b1); feed(1'b0);
    chk("stop_pre_busy", busy, 1);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("stop_ro", ro_en, 0);
    chk("stop_busy", busy, 0);
    chk("stop_valid", valid, 0);
    start_run("fresh");
    feed(1); feed(1); feed(0); feed(0); feed(1); feed(1); feed(0);
    chk("fresh_not_early", valid, 0);
    feed(0);
    chk("fresh_valid", valid, 1);
    chk("fresh_word", word, 8'hCC);

    // Asynchronous reset while holding a word, checked before the next edge.
    #2 rst = 1'b1;
    #1;
    all_zero("async_rst");
    tick();
    rst = 1'b0;
    tick();
    all_zero("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/trng_ctrl.md
Name: trng_ctrl

Overview:
- Sequencer for the ring-oscillator entropy source (`ro_comb`).
- Enables the RO bank and waits out oscillator settling plus the XOR-tree pipeline.
- Decimates the combined raw bit stream, runs a repetition-count health test, and packs accepted bits into words.
- Delivers words downstream over a valid/ready handshake. Sits between `ro_comb` and the consumer (entropy FIFO/bus).

Parameters:
- WORD_W, 32: output word width in bits (>=2).
- WARMUP_CYCLES, 256: cycles spent in WARMUP with ro_enable high before sampling (>=1; must exceed XOR-tree depth+1).
- SAMPLE_DIV, 4: one raw_bit sample every SAMPLE_DIV cycles in COLLECT (>=1).
- REP_LIMIT, 32: consecutive identical samples that trigger a health fault (2..255).

Ports:
- clock, input, 1: sole clock; all logic on rising edge.
- reset, input, 1: asynchronous, active-high; forces all state to reset values.
- start, input, 1: single-cycle request to begin generation; honoured only in IDLE.
- stop, input, 1: request to return to IDLE; honoured in WARMUP/COLLECT/HOLD.
- clear_fault, input, 1: leaves FAULT to IDLE; ignored elsewhere.
- raw_bit, input, 1: combined RO output (`output_comb`), synchronous to clock.
- ro_enable, output, 1: registered enable to `ro_comb`.
- word_out, output, WORD_W: assembled random word; valid only with word_valid.
- word_valid, output, 1: word_out holds a complete word.
- word_ready, input, 1: consumer accepts word on a cycle with word_valid&&word_ready.
- health_fail, output, 1: sticky fault flag.
- busy, output, 1: high in any state other than IDLE and FAULT.

Behaviour:
- Reset values: state=IDLE, ro_enable=0, word_out=0, word_valid=0, health_fail=0, busy=0, all counters 0.
- States: IDLE, WARMUP, COLLECT, HOLD, FAULT; all outputs registered.
- IDLE: start=1 -> WARMUP at next edge; ro_enable=1 and warm-up counter cleared at that same edge.
- WARMUP: counts WARMUP_CYCLES cycles, then -> COLLECT. Repetition counter and bit counter are cleared on WARMUP entry.
- COLLECT sampling:
  - A divider counts 0..SAMPLE_DIV-1 and samples raw_bit when it equals SAMPLE_DIV-1, so the first sample lands SAMPLE_DIV cycles after COLLECT entry.
  - Each sample shifts in at bit 0 with the register shifting left, so the first sampled bit ends at bit WORD_W-1.
- Word completion: the edge capturing the WORD_W-th bit sets word_valid=1 and enters HOLD.
- HOLD:
  - Sampling suspended; divider held at 0; word_out stable.
  - On handshake: word_valid=0 and bit counter cleared at that edge -> COLLECT; the next word's first sample comes SAMPLE_DIV cycles later.
- Health test:
  - The repetition count is 1 after the first sample.
  - It increments when a sample equals the previous sample and resets to 1 when it differs.
  - It is preserved across HOLD.
  - When the count reaches REP_LIMIT, at that edge: -> FAULT, health_fail=1, ro_enable=0, the partial word is discarded (word_valid stays 0).
- FAULT: start and stop ignored. clear_fault=1 -> IDLE, with health_fail=0 at next edge.
- stop (any of WARMUP/COLLECT/HOLD) -> IDLE at next edge: ro_enable=0, word_valid=0, partial or held word discarded.
- Simultaneous events:
  - stop and start in IDLE: stay IDLE.
  - stop and handshake in HOLD: the handshake counts as completed, then IDLE.
  - stop and a health trip on the same edge: FAULT wins.
- reset asserted mid-operation: immediate return to reset values regardless of clock.

Decomposition:
- params.vh gains defaults: `TRNG_WORD_W, `TRNG_WARMUP, `TRNG_SAMPLE_DIV, `TRNG_REP_LIMIT.
- State encodings are localparams inside trng_ctrl.
- One sub-module: trng_rep_test. Inputs: clock, reset, clear, sample_en, bit. Output: trip. Holds the last bit and an 8-bit saturating count.

Test Plan (WORD_W=8, WARMUP_CYCLES=4, SAMPLE_DIV=2, REP_LIMIT=5):
- start pulse, raw_bit alternating 1,0 at each sample instant, word_ready=1:
  - ro_enable rises 1 cycle after start; first sample 6 cycles after start.
  - word_valid after 8 samples with word_out=0xAA; health_fail stays 0.
- Constant raw_bit=1 after start:
  - FAULT on the 5th sample: health_fail=1, ro_enable=0, no word_valid.
  - clear_fault -> busy=0, health_fail=0.
- Backpressure: word_ready=0 for 10 cycles after word_valid:
  - word_out stable and word_valid held.
  - No repetition-count change; next word's first sample 2 cycles after the handshake.
- stop after 3 samples in COLLECT -> IDLE next edge, ro_enable=0. A new start yields a full fresh word with no stale bits (pattern 0xCC reproduced exactly).
- reset asserted asynchronously during HOLD -> word_valid, ro_enable and busy drop before the next clock edge; all outputs at reset values.
- Pattern 1,1,1,1,0 repeated: count peaks at 4, never trips; words 0xF7, 0xBD... delivered normally.
